// File: rtl/memory_access.sv
// Memory stage: turns the execute result into a data-memory access and a register write-back.
// One access in flight; ALU ops retire in 1 cycle, memory ops wait on mem_ready up to MAX_WAIT edges.
module memory_access #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic        reg_we,
  input  logic [4:0]  rd_idx,
  input  logic [31:0] alu_rd,
  input  logic [31:0] rs2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        completed,
  output logic        wb_we,
  output logic [4:0]  wb_idx,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_lane;
  logic            r_is_load;
  logic            r_reg_we;

  logic            w_is_st;
  logic            w_mem;
  logic            w_misal;
  logic [3:0]      w_wstrb;
  logic [31:0]     w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ld;

  assign completed = (r_state == IDLE) & ~enabled;

  // Loads take priority if execute ever flags both; such an op is treated as a load.
  always_comb begin
    w_is_st = is_store & ~is_load;
    w_mem   = is_load | is_store;
    w_misal = 1'b0;
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b100: w_misal = 1'b0;
        3'b001, 3'b101: w_misal = alu_rd[0];
        3'b010:         w_misal = |alu_rd[1:0];
        default:        w_misal = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000: begin
          w_wstrb = 4'b0001 << alu_rd[1:0];
          w_wdata = {4{rs2[7:0]}};
        end
        3'b001: begin
          w_misal = alu_rd[0];
          w_wstrb = alu_rd[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{rs2[15:0]}};
        end
        3'b010: begin
          w_misal = |alu_rd[1:0];
          w_wstrb = 4'b1111;
          w_wdata = rs2;
        end
        default: w_misal = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld = {24'h0, w_byte};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld = {16'h0, w_half};
      default: w_ld = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_funct3   <= 3'b000;
      r_lane     <= 2'b00;
      r_is_load  <= 1'b0;
      r_reg_we   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0;
      wb_we      <= 1'b0;
      wb_idx     <= 5'd0;
      wb_data    <= 32'h0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      wb_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enabled) begin
            r_funct3   <= funct3;
            r_lane     <= alu_rd[1:0];
            r_is_load  <= is_load;
            r_reg_we   <= reg_we;
            r_cnt      <= '0;
            wb_idx     <= rd_idx;
            wb_data    <= alu_rd;
            misaligned <= w_mem & w_misal;
            bus_err    <= 1'b0;
            if (w_mem && !w_misal) begin
              r_state   <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= w_is_st;
              mem_addr  <= {alu_rd[31:2], 2'b00};
              mem_wstrb <= w_is_st ? w_wstrb : 4'b0000;
              mem_wdata <= w_is_st ? w_wdata : 32'h0;
            end else begin
              r_state <= WB;
              wb_we   <= ~w_mem & reg_we & (|rd_idx);
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            r_state <= WB;
            mem_req <= 1'b0;
            if (r_is_load) wb_data <= w_ld;
            wb_we   <= r_is_load & r_reg_we & (|wb_idx);
          end else if (r_cnt >= CW'(MAX_WAIT - 1)) begin
            // Timed out: abandon the access and suppress write-back.
            r_state <= WB;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized checks of memory_access against a transaction-level reference model.
module tb_memory_access;

  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        reg_we = 1'b0;
  logic [4:0]  rd_idx = 5'd0;
  logic [31:0] alu_rd = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        completed, wb_we, misaligned, bus_err;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;

  int n_chk = 0;
  int n_fail = 0;

  memory_access #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .reg_we(reg_we), .rd_idx(rd_idx), .alu_rd(alu_rd), .rs2(rs2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .completed(completed), .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned v;
    int unsigned b;
    int unsigned h;
    v = w >> (8 * (a % 4));
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Issue one op at the current idle cycle (#1 after an edge) and check everything it produces.
  // delay = number of REQ cycles the memory waits before asserting mem_ready.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input bit we,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input int delay);
    bit mem, bad, berr, exp_wb;
    int size, exp_req, exp_done, exp_wbc;
    logic [3:0] exp_strb;
    logic [31:0] exp_wdata, exp_data;
    int reqn, wbn, wbc, done, c;
    logic [31:0] s_addr, s_wdata, o_wbd;
    logic [3:0] s_strb;
    logic s_we;
    logic [4:0] o_wbi;
    bit unstable;

    // Reference model.
    mem = ld | st;
    size = 0;
    if (ld) size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    if (st) size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    bad = mem && (size == 0 || (a % size) != 0);
    berr = mem && !bad && delay >= MAX_WAIT;
    if (!mem || bad) begin
      exp_req = 0; exp_done = 2; exp_wbc = 1;
    end else if (!berr) begin
      exp_req = delay + 1; exp_done = delay + 3; exp_wbc = delay + 2;
    end else begin
      exp_req = MAX_WAIT; exp_done = MAX_WAIT + 2; exp_wbc = -1;
    end
    exp_wb = !bad && !berr && we && rd != 0 && !st;
    exp_data = ld ? ref_load(f3, a, rdata) : a;
    exp_strb = 4'd0;
    exp_wdata = 32'h0;
    if (st && size == 1) begin exp_strb = 4'(1 << (a % 4)); exp_wdata = d[7:0] * 32'h0101_0101; end
    if (st && size == 2) begin exp_strb = (a % 4 == 2) ? 4'hC : 4'h3; exp_wdata = d[15:0] * 32'h0001_0001; end
    if (st && size == 4) begin exp_strb = 4'hF; exp_wdata = d; end

    chk("idle_completed", {31'd0, completed}, 32'd1);
    enabled = 1'b1; is_load = ld; is_store = st; funct3 = f3; reg_we = we;
    rd_idx = rd; alu_rd = a; rs2 = d; mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
    #1;
    chk("completed_while_enabled", {31'd0, completed}, 32'd0);
    @(posedge clk); #1;
    enabled = 1'b0; is_load = 1'($urandom % 2); is_store = 1'($urandom % 2);
    funct3 = 3'($urandom); reg_we = 1'($urandom % 2); rd_idx = 5'($urandom);
    alu_rd = $urandom; rs2 = $urandom;

    reqn = 0; wbn = 0; wbc = -1; done = -1; unstable = 0;
    s_addr = 0; s_wdata = 0; s_strb = 0; s_we = 0; o_wbd = 0; o_wbi = 0;
    for (c = 1; c <= 40; c++) begin
      if (c == 1) chk("err_cleared", {30'd0, misaligned, bus_err}, {30'd0, bad, 1'b0});
      if (mem_req) begin
        reqn++;
        if (reqn == 1) begin
          s_addr = mem_addr; s_we = mem_we; s_strb = mem_wstrb; s_wdata = mem_wdata;
        end else if (mem_addr !== s_addr || mem_we !== s_we || mem_wstrb !== s_strb ||
                     mem_wdata !== s_wdata) begin
          unstable = 1;
        end
        mem_ready = (reqn - 1 == delay);
        mem_rdata = mem_ready ? rdata : $urandom;
      end else begin
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
      end
      if (wb_we) begin
        wbn++; wbc = c; o_wbd = wb_data; o_wbi = wb_idx;
      end
      if (completed) begin
        done = c;
        break;
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;

    chk("done_cycle", done, exp_done);
    chk("req_cycles", reqn, exp_req);
    chk("misaligned", {31'd0, misaligned}, {31'd0, bad});
    chk("bus_err", {31'd0, bus_err}, {31'd0, berr});
    chk("wb_count", wbn, exp_wb ? 1 : 0);
    chk("mem_stable", {31'd0, unstable}, 32'd0);
    if (exp_wb) begin
      chk("wb_cycle", wbc, exp_wbc);
      chk("wb_idx", {27'd0, o_wbi}, {27'd0, rd});
      chk("wb_data", o_wbd, exp_data);
    end
    if (exp_req > 0) begin
      chk("mem_addr", s_addr, a & 32'hFFFF_FFFC);
      chk("mem_we", {31'd0, s_we}, {31'd0, st});
      chk("mem_wstrb", {28'd0, s_strb}, {28'd0, exp_strb});
      if (st) chk("mem_wdata", s_wdata, exp_wdata);
    end
  endtask

  initial begin
    int seen_wb;
    int kind;
    int dly;
    #3;
    chk("rst_completed", {31'd0, completed}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_outputs", {wb_we, wb_idx, misaligned, bus_err, mem_we, mem_wstrb},
        {32'd0});
    chk("rst_wb_data", wb_data, 32'h0);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 3'd0, 1, 5'd5, 32'h1234, 32'h0, 32'h0, 0);
    run_op(0, 0, 3'd0, 1, 5'd0, 32'h5678, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'd0, 1, 5'd7, 32'h103, 32'h0, 32'h80FF_0000, 3);
    run_op(1, 0, 3'd4, 1, 5'd8, 32'h103, 32'h0, 32'h80FF_0000, 3);
    run_op(0, 1, 3'd1, 1, 5'd9, 32'h202, 32'hABCD_1234, 32'h0, 0);
    run_op(1, 0, 3'd2, 1, 5'd3, 32'h101, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'd2, 1, 5'd4, 32'h400, 32'h0, 32'hDEAD_BEEF, 99);
    run_op(1, 0, 3'd5, 1, 5'd4, 32'h402, 32'h0, 32'h8001_7FFF, 0);
    run_op(1, 0, 3'd3, 1, 5'd4, 32'h400, 32'h0, 32'h0, 0);
    run_op(0, 1, 3'd2, 0, 5'd1, 32'h800, 32'h1122_3344, 32'h0, 15);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      dly = ($urandom_range(0, 9) == 0) ? MAX_WAIT + 2 : $urandom_range(0, 4);
      run_op(kind == 1 || kind == 3, kind == 2, 3'($urandom), 1'($urandom % 2),
             5'($urandom), $urandom, $urandom, $urandom, dly);
    end

    // Asynchronous reset in the middle of an outstanding load.
    enabled = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; reg_we = 1'b1;
    rd_idx = 5'd6; alu_rd = 32'h900; mem_ready = 1'b0;
    @(posedge clk); #1; enabled = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, mem_req}, 32'd0);
    chk("async_completed", {31'd0, completed}, 32'd1);
    @(posedge clk); #1; rstn = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1;
    seen_wb = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (wb_we || mem_req) seen_wb++;
    end
    mem_ready = 1'b0;
    chk("no_wb_after_rst", seen_wb, 0);
    run_op(0, 0, 3'd0, 1, 5'd31, 32'hCAFE_F00D, 32'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
